// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master controller.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WDATA,
    WACK,
    RDATA,
    RACK,
    STOP
  } i2c_state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_qtr_tick.sv
// SCL quarter-period divider: DIV cycles per quarter, four quarters per bit.
// While stall is high the divider freezes in place (used for clock stretching).
module i2c_qtr_tick
  import i2c_pkg::*;
#(
  parameter int DIV = 125
) (
  input  logic       system_clock,
  input  logic       reset_n,
  input  logic       run,
  input  logic       stall,
  output logic       tick,
  output logic       qstart,
  output logic [1:0] phase
);

  localparam int QW = $clog2(DIV);
  localparam logic [QW-1:0] LAST = QW'(DIV - 1);

  logic [QW-1:0] cnt;

  assign qstart = (cnt == '0);
  assign tick   = run && !stall && (cnt == LAST);

  // Parked at q0/count 0 while idle so a new command starts on a clean bit boundary.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (!run) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (!stall) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        phase <= phase + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master: START, address, data bytes with ACK/NACK, STOP.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching on scl_i.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int DIV = 125
) (
  input  logic       system_clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [3:0] cmd_len,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       scl_i,
  input  logic       sda_i
);

  i2c_state_t state, state_next;

  logic       tick;
  logic       qstart;
  logic [1:0] phase;
  logic       stall;
  logic       bit_end;
  logic       sample;
  logic       scl_bit;
  logic       accept;

  logic       rw;
  logic [3:0] byte_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       ack_bit;

`ifdef I2C_CLK_STRETCH_EN
  assign stall = (state != IDLE) && (phase == Q2) && qstart && !scl_i;
`else
  logic unused_scl_i;
  assign unused_scl_i = scl_i;
  assign stall        = 1'b0;
`endif

  i2c_qtr_tick #(.DIV(DIV)) u_tick (
    .system_clock(system_clock),
    .reset_n     (reset_n),
    .run         (state != IDLE),
    .stall       (stall),
    .tick        (tick),
    .qstart      (qstart),
    .phase       (phase)
  );

  assign bit_end   = tick && (phase == Q3);
  assign sample    = (state != IDLE) && (phase == Q3) && qstart;
  assign scl_bit   = (phase == Q2) || (phase == Q3);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign wr_ready  = (state == WDATA) && (phase == Q0) && qstart && (bit_cnt == 3'd7);

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    scl_o      = 1'b1;
    sda_o      = 1'b1;
    case (state)
      IDLE: if (cmd_valid) state_next = START;
      START: begin
        sda_o = (phase == Q0) || (phase == Q1);
        if (bit_end) state_next = ADDR;
      end
      ADDR: begin
        scl_o = scl_bit;
        sda_o = shift[bit_cnt];
        if (bit_end && bit_cnt == 3'd0) state_next = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl_o = scl_bit;
        if (bit_end) begin
          if (ack_bit || byte_cnt == 4'd0) state_next = STOP;
          else if (rw == I2C_READ)         state_next = RDATA;
          else                             state_next = WDATA;
        end
      end
      WDATA: begin
        scl_o = scl_bit;
        // The new byte is still on wr_data during its consume cycle.
        sda_o = wr_ready ? wr_data[7] : shift[bit_cnt];
        if (bit_end && bit_cnt == 3'd0) state_next = WACK;
      end
      WACK: begin
        scl_o = scl_bit;
        if (bit_end) state_next = (ack_bit || byte_cnt == 4'd1) ? STOP : WDATA;
      end
      RDATA: begin
        scl_o = scl_bit;
        if (bit_end && bit_cnt == 3'd0) state_next = RACK;
      end
      RACK: begin
        scl_o = scl_bit;
        sda_o = (byte_cnt == 4'd1);
        if (bit_end) state_next = (byte_cnt == 4'd1) ? STOP : RDATA;
      end
      STOP: begin
        scl_o = (phase != Q0);
        sda_o = (phase == Q3);
        if (bit_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // bit_cnt wraps 0 -> 7 at each byte end, so it is already 7 for the next byte.
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      rw       <= I2C_WRITE;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      ack_bit  <= 1'b1;
      nack     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      if (accept) begin
        rw       <= cmd_rw;
        byte_cnt <= cmd_len;
        shift    <= {cmd_addr, cmd_rw};
        bit_cnt  <= 3'd7;
        nack     <= 1'b0;
      end
      if (sample) ack_bit <= sda_i;
      if (wr_ready) shift <= wr_data;
      if (state == RDATA && sample) begin
        shift <= {shift[6:0], sda_i};
        if (bit_cnt == 3'd0) begin
          rd_valid <= 1'b1;
          rd_data  <= {shift[6:0], sda_i};
        end
      end
      if (bit_end) begin
        case (state)
          ADDR, WDATA, RDATA: bit_cnt <= bit_cnt - 3'd1;
          ADDR_ACK: if (ack_bit) nack <= 1'b1;
          WACK: begin
            if (ack_bit) nack     <= 1'b1;
            else         byte_cnt <= byte_cnt - 4'd1;
          end
          RACK: byte_cnt <= byte_cnt - 4'd1;
          STOP: done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Self-checking bench: bit-level bus model per transaction, compared every cycle.
module tb_i2c_master_ctrl;

  localparam int DIV = 4;
  localparam int BT  = 4 * DIV;
  localparam int NB  = 160;
  localparam int K_START = 0, K_DATA = 1, K_STOP = 2;
  localparam int STRETCH_AT  = 5 * BT + 2 * DIV;
  localparam int STRETCH_LEN = 50;

  logic       system_clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [6:0] cmd_addr = '0;
  logic       cmd_rw = 1'b0;
  logic [3:0] cmd_len = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy, done, nack;
  logic       scl_o, sda_o, scl_i, sda_i;
  logic       slave_lvl = 1'b1;
  logic       hold = 1'b0;

  assign sda_i = sda_o & slave_lvl;
  assign scl_i = scl_o & ~hold;

  always #5 system_clock = ~system_clock;

  i2c_master_ctrl #(.DIV(DIV)) dut (
    .system_clock(system_clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_rw(cmd_rw), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .nack(nack),
    .scl_o(scl_o), .sda_o(sda_o), .scl_i(scl_i), .sda_i(sda_i)
  );

  int         tests = 0, fails = 0;
  int         kind [NB];
  logic       mlev [NB], slev [NB], wrr [NB], rdv [NB], obs_sda [NB];
  logic [7:0] rdb [NB], wdb [NB];
  logic [7:0] wbytes [16], rbytes [16];
  int         nbits;
  logic       exp_nack;
  logic [7:0] rd_q [$];
  int         wr_count, done_real;
  logic       done_nack;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Bus contents bit by bit: what the master drives and what the slave drives.
  task automatic build_model(input logic [6:0] a, input logic rw, input int len,
                             input bit addr_ack, input int nack_byte);
    int b;
    logic [7:0] ab;
    ab = {a, rw};
    b  = 0;
    for (int i = 0; i < NB; i++) begin
      kind[i] = K_DATA; mlev[i] = 1'b1; slev[i] = 1'b1;
      wrr[i] = 1'b0; rdv[i] = 1'b0; rdb[i] = '0; wdb[i] = '0;
    end
    exp_nack = 1'b0;
    kind[b] = K_START; b++;
    for (int i = 7; i >= 0; i--) begin mlev[b] = ab[i]; b++; end
    slev[b] = !addr_ack; b++;
    if (!addr_ack) exp_nack = 1'b1;
    else begin
      for (int n = 0; n < len; n++) begin
        if (rw == 1'b0) begin
          wrr[b] = 1'b1;
          for (int i = 7; i >= 0; i--) begin mlev[b] = wbytes[n][i]; wdb[b] = wbytes[n]; b++; end
          slev[b] = (n == nack_byte); b++;
          if (n == nack_byte) begin exp_nack = 1'b1; break; end
        end else begin
          for (int i = 7; i >= 0; i--) begin slev[b] = rbytes[n][i]; b++; end
          rdv[b-1] = 1'b1; rdb[b-1] = rbytes[n];
          mlev[b] = (n == len - 1); b++;
        end
      end
    end
    kind[b] = K_STOP; b++;
    nbits = b;
  endtask

  // {scl_o, sda_o, busy, cmd_ready, wr_ready, rd_valid, done} at model cycle m.
  function automatic logic [6:0] expect_at(input int m);
    int b, q, r;
    logic scl, sda, wr, rv;
    if (m >= nbits * BT) return 7'b1101001;
    b = m / BT; r = m % BT; q = r / DIV;
    case (kind[b])
      K_START: begin scl = 1'b1;    sda = (q < 2);    end
      K_STOP:  begin scl = (q != 0); sda = (q == 3);  end
      default: begin scl = (q >= 2); sda = mlev[b];   end
    endcase
    wr = wrr[b] && (r == 0);
    rv = rdv[b] && (r == 3 * DIV + 1);
    return {scl, sda, 1'b1, 1'b0, wr, rv, 1'b0};
  endfunction

  function automatic logic [7:0] obs_byte(input int first);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[7-i] = obs_sda[first + i];
    return v;
  endfunction

  task automatic run_txn(input logic [6:0] a, input logic rw, input int len, input bit addr_ack,
                         input int nack_byte, input bit stretch, input int abort_at);
    int m, real_c, total, b, hold_used;
    logic [6:0] want, got;
    build_model(a, rw, len, addr_ack, nack_byte);
    total = nbits * BT;
    wr_count = 0; done_real = -1; done_nack = 1'b0; hold_used = 0;
    rd_q.delete();
    for (int i = 0; i < NB; i++) obs_sda[i] = 1'b1;
    @(negedge system_clock);
    cmd_addr = a; cmd_rw = rw; cmd_len = 4'(len); cmd_valid = 1'b1;
    slave_lvl = 1'b1; hold = 1'b0;
    #1 check("accept_ready", cmd_ready, 1);
    @(posedge system_clock);
    m = 0; real_c = 0;
    while (m <= total) begin
      @(negedge system_clock);
      b = (m < total) ? m / BT : 0;
      cmd_valid = (m < total - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_addr  = 7'($urandom);
      cmd_rw    = 1'($urandom);
      cmd_len   = 4'($urandom);
      wr_data   = (m < total) ? wdb[b] : 8'h00;
      slave_lvl = (m < total) ? slev[b] : 1'b1;
      hold      = stretch && (m == STRETCH_AT) && (hold_used < STRETCH_LEN);
      if (hold) hold_used++;
      #1;
      want = expect_at(m);
      got  = {scl_o, sda_o, busy, cmd_ready, wr_ready, rd_valid, done};
      check($sformatf("outputs@%0d", m), got, want);
      if (want[1]) check($sformatf("rd_data@%0d", m), rd_data, rdb[b]);
      if (m == 0) check("nack_cleared", nack, 0);
      if (m == total) check("nack_at_done", nack, exp_nack);
      if (m < total && (m % BT) == 2 * DIV) obs_sda[b] = sda_o;
      if (wr_ready) wr_count++;
      if (rd_valid) rd_q.push_back(rd_data);
      if (done && done_real < 0) begin done_real = real_c; done_nack = nack; end
      if (m == abort_at) begin
        cmd_valid = 1'b0; hold = 1'b0; slave_lvl = 1'b1;
        reset_n = 1'b0;
        #1;
        check("rst_scl", scl_o, 1);
        check("rst_sda", sda_o, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_data", rd_data, 0);
        @(negedge system_clock);
        reset_n = 1'b1;
        #1 check("rst_ready", cmd_ready, 1);
        return;
      end
      if (!hold) m++;
      real_c++;
    end
    hold = 1'b0; slave_lvl = 1'b1; cmd_valid = 1'b0;
  endtask

  initial begin
    int len, nb;
    repeat (3) @(negedge system_clock);
    #1;
    check("reset_scl", scl_o, 1);
    check("reset_sda", sda_o, 1);
    check("reset_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_nack", nack, 0);
    check("reset_wr_ready", wr_ready, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    reset_n = 1'b1;

    wbytes[0] = 8'hA5;
    run_txn(7'h50, 1'b0, 1, 1'b1, -1, 1'b0, -1);
    check("w1_addr_byte", obs_byte(1), 8'hA0);
    check("w1_data_byte", obs_byte(10), 8'hA5);
    check("w1_done_cycle", done_real, 320);
    check("w1_nack", done_nack, 0);
    check("w1_wr_pulses", wr_count, 1);

    rbytes[0] = 8'h12; rbytes[1] = 8'h34;
    run_txn(7'h3C, 1'b1, 2, 1'b1, -1, 1'b0, -1);
    check("r2_count", rd_q.size(), 2);
    if (rd_q.size() == 2) begin
      check("r2_byte0", rd_q[0], 8'h12);
      check("r2_byte1", rd_q[1], 8'h34);
    end
    check("r2_master_ack", obs_sda[18], 0);
    check("r2_master_nack", obs_sda[27], 1);
    check("r2_done_cycle", done_real, 464);

    run_txn(7'h7F, 1'b0, 0, 1'b0, -1, 1'b0, -1);
    check("probe_done_cycle", done_real, 176);
    check("probe_nack", done_nack, 1);

    for (int i = 0; i < 3; i++) wbytes[i] = 8'($urandom);
    run_txn(7'h21, 1'b0, 3, 1'b1, 1, 1'b0, -1);
    check("wn_wr_pulses", wr_count, 2);
    check("wn_nack", done_nack, 1);
    check("wn_done_cycle", done_real, 464);

    rbytes[0] = 8'h5A; rbytes[1] = 8'hC3;
    run_txn(7'h2A, 1'b1, 2, 1'b1, -1, 1'b0, 12 * BT + 5);

    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(0, 4);
      nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      for (int i = 0; i < 16; i++) begin
        wbytes[i] = 8'($urandom);
        rbytes[i] = 8'($urandom);
      end
      run_txn(7'($urandom), 1'($urandom), len, ($urandom_range(0, 7) != 0), nb, 1'b0, -1);
    end

`ifdef I2C_CLK_STRETCH_EN
    wbytes[0] = 8'hA5;
    run_txn(7'h50, 1'b0, 1, 1'b1, -1, 1'b1, -1);
    check("stretch_done_cycle", done_real, 320 + STRETCH_LEN);
    check("stretch_nack", done_nack, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
